xram_arbiter: RTL and testbench
===============================

XRAM_ARBITER -- requirements
Module: xram_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 8'd255; maximum cycles a granted transaction may wait for xram_ack before it is aborted.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 cpu_xram_addr / cpu_xram_data_out / cpu_xram_stb / cpu_xram_wr  input  16/8/1/1  CPU-side requester: address, write data, strobe, write enable.
REQ-005 cpu_xram_data_in  output  8  read data returned to the CPU requester.
REQ-006 cpu_xram_ack  output  1  transaction-complete pulse to the CPU requester.
REQ-007 acc_xram_addr / acc_xram_data_out / acc_xram_stb / acc_xram_wr  input  16/8/1/1  accelerator (memwr DMA) requester: same meanings as the CPU group.
REQ-008 acc_xram_data_in / acc_xram_ack  output  8/1  read data and ack to the accelerator.
REQ-009 xram_addr / xram_data_out / xram_stb / xram_wr  output  16/8/1/1  shared XRAM port driven from the granted requester.
REQ-010 xram_data_in / xram_ack  input  8/1  XRAM read data and completion.
REQ-011 arb_state  output  2  current state: 00 IDLE, 01 GNT_CPU, 10 GNT_ACC.
REQ-012 arb_timeout  output  1  one-cycle pulse when a transaction is aborted by timeout.

Function
REQ-013 The block SHALL implement the FSM IDLE, GNT_CPU, GNT_ACC; encoding 11 SHALL transition to IDLE on the next cycle.
REQ-014 In IDLE: cpu stb only -> GNT_CPU; acc stb only -> GNT_ACC; both asserted -> the requester not in last_gnt; neither -> stay IDLE.
REQ-015 last_gnt (1 bit, 0=CPU, 1=ACC) SHALL update on every IDLE->GNT transition; reset value 1, so the CPU wins the first tie.
REQ-016 Grant latency: a request sampled in IDLE on cycle N SHALL see xram_stb=1 on cycle N+1; the arbiter SHALL not forward anything during IDLE.
REQ-017 In GNT_x, xram_addr, xram_data_out and xram_wr SHALL combinationally equal requester x's inputs, and xram_stb SHALL equal x's stb.
REQ-018 In IDLE, all xram_* outputs SHALL be 0.
REQ-019 xram_ack SHALL be routed combinationally to the granted requester's ack only, and xram_data_in to its data_in only.
REQ-020 The ungranted requester SHALL see ack=0 and data_in=8'h00.
REQ-021 In GNT_x, xram_ack=1 SHALL cause a return to IDLE next cycle; the minimum turnaround is one IDLE cycle between grants.
REQ-022 If requester x deasserts stb while in GNT_x without an ack, the FSM SHALL return to IDLE next cycle and no ack SHALL be issued.
REQ-023 wait_cnt (8 bit) SHALL clear on entry to a GNT state and increment each GNT cycle without xram_ack.
REQ-024 If wait_cnt==TIMEOUT with no xram_ack, the block SHALL go to IDLE, pulse arb_timeout for one cycle, and issue no ack.
REQ-025 wait_cnt SHALL saturate and never wrap.
REQ-026 Simultaneous xram_ack and timeout on the same cycle SHALL be treated as a normal ack: ack delivered, no arb_timeout.
REQ-027 Round-robin SHALL bound starvation: with both requesters continuously asserting stb, grants alternate CPU, ACC, CPU, ...

Reset
REQ-028 With rst=1 at a posedge: arb_state=IDLE, last_gnt=1, wait_cnt=0, arb_timeout=0; all xram_* and both requester ack/data_in outputs SHALL be 0 from the following cycle.
REQ-029 Reset mid-grant SHALL abandon the transaction without an ack; xram_ack arriving during or after reset while in IDLE SHALL be ignored.

Verification
REQ-030 Tie after reset: both stb=1 in cycle 1 -> arb_state=01 in cycle 2 with xram_addr=cpu_xram_addr; xram_ack in cycle 4 -> cpu_xram_ack=1, acc_xram_ack=0, IDLE in cycle 5, GNT_ACC in cycle 6.
REQ-031 Read routing: acc read at 16'h0100, xram_data_in=8'hA5 with ack -> acc_xram_data_in=8'hA5, cpu_xram_data_in=8'h00.
REQ-032 Write forwarding: cpu write 8'h3C to 16'hF000 -> xram_wr=1, xram_data_out=8'h3C, xram_addr=16'hF000 throughout the grant.
REQ-033 Timeout: with TIMEOUT=4, grant CPU and hold xram_ack=0 -> arb_timeout pulses exactly once, 5 cycles after grant entry; no cpu_xram_ack; state IDLE next cycle.
REQ-034 Alternation and abort: both requesters hold stb for 6 transactions -> grant order C,A,C,A,C,A; acc stb dropped mid-grant -> IDLE next cycle, no acc_xram_ack.
REQ-035 Reset mid-grant: rst during GNT_ACC with xram_ack=1 on the same cycle -> no acc_xram_ack, arb_state=00, last_gnt=1.

Source files
------------

// File: rtl/xram_arbiter.sv
// Two-requester XRAM arbiter (CPU and accelerator DMA) with a round-robin tie-break
// and a per-transaction ack timeout.
module xram_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [15:0] cpu_xram_addr,
    input  logic [7:0]  cpu_xram_data_out,
    input  logic        cpu_xram_stb,
    input  logic        cpu_xram_wr,
    output logic [7:0]  cpu_xram_data_in,
    output logic        cpu_xram_ack,

    input  logic [15:0] acc_xram_addr,
    input  logic [7:0]  acc_xram_data_out,
    input  logic        acc_xram_stb,
    input  logic        acc_xram_wr,
    output logic [7:0]  acc_xram_data_in,
    output logic        acc_xram_ack,

    output logic [15:0] xram_addr,
    output logic [7:0]  xram_data_out,
    output logic        xram_stb,
    output logic        xram_wr,
    input  logic [7:0]  xram_data_in,
    input  logic        xram_ack,

    output logic [1:0]  arb_state,
    output logic        arb_timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GNT_CPU = 2'b01,
        GNT_ACC = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        last_gnt;
    logic        last_gnt_next;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_cnt_next;
    logic        arb_timeout_next;
    logic        gnt_stb;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_gnt    <= 1'b1;
            wait_cnt    <= '0;
            arb_timeout <= 1'b0;
        end else begin
            state       <= state_next;
            last_gnt    <= last_gnt_next;
            wait_cnt    <= wait_cnt_next;
            arb_timeout <= arb_timeout_next;
        end
    end

    always_comb begin
        state_next       = state;
        last_gnt_next    = last_gnt;
        wait_cnt_next    = wait_cnt;
        arb_timeout_next = 1'b0;
        gnt_stb          = (state == GNT_CPU) ? cpu_xram_stb : acc_xram_stb;

        case (state)
            IDLE: begin
                wait_cnt_next = '0;
                if (cpu_xram_stb && (!acc_xram_stb || last_gnt)) begin
                    state_next    = GNT_CPU;
                    last_gnt_next = 1'b0;
                end else if (acc_xram_stb) begin
                    state_next    = GNT_ACC;
                    last_gnt_next = 1'b1;
                end
            end
            GNT_CPU, GNT_ACC: begin
                // An ack wins over a coincident timeout: the transfer completed.
                if (xram_ack) begin
                    state_next = IDLE;
                end else if (!gnt_stb) begin
                    state_next = IDLE;
                end else if (wait_cnt == TIMEOUT) begin
                    state_next       = IDLE;
                    arb_timeout_next = 1'b1;
                end else if (wait_cnt != 8'hFF) begin
                    wait_cnt_next = wait_cnt + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        xram_addr        = '0;
        xram_data_out    = '0;
        xram_stb         = 1'b0;
        xram_wr          = 1'b0;
        cpu_xram_ack     = 1'b0;
        cpu_xram_data_in = '0;
        acc_xram_ack     = 1'b0;
        acc_xram_data_in = '0;

        // Returns are masked during reset so an abandoned grant never completes.
        case (state)
            GNT_CPU: begin
                xram_addr     = cpu_xram_addr;
                xram_data_out = cpu_xram_data_out;
                xram_stb      = cpu_xram_stb;
                xram_wr       = cpu_xram_wr;
                if (!rst) begin
                    cpu_xram_ack     = xram_ack;
                    cpu_xram_data_in = xram_data_in;
                end
            end
            GNT_ACC: begin
                xram_addr     = acc_xram_addr;
                xram_data_out = acc_xram_data_out;
                xram_stb      = acc_xram_stb;
                xram_wr       = acc_xram_wr;
                if (!rst) begin
                    acc_xram_ack     = xram_ack;
                    acc_xram_data_in = xram_data_in;
                end
            end
            default: ;
        endcase
    end

    assign arb_state = state;

endmodule

// File: tb/tb_xram_arbiter.sv
// Directed bench for xram_arbiter built with TIMEOUT=4; every check is an
// immediate assertion against hand-computed values.
module tb_xram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_xram_addr;
    logic [7:0]  cpu_xram_data_out;
    logic        cpu_xram_stb;
    logic        cpu_xram_wr;
    logic [7:0]  cpu_xram_data_in;
    logic        cpu_xram_ack;
    logic [15:0] acc_xram_addr;
    logic [7:0]  acc_xram_data_out;
    logic        acc_xram_stb;
    logic        acc_xram_wr;
    logic [7:0]  acc_xram_data_in;
    logic        acc_xram_ack;
    logic [15:0] xram_addr;
    logic [7:0]  xram_data_out;
    logic        xram_stb;
    logic        xram_wr;
    logic [7:0]  xram_data_in;
    logic        xram_ack;
    logic [1:0]  arb_state;
    logic        arb_timeout;

    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    xram_arbiter #(.TIMEOUT(8'd4)) dut (
        .clk               (clk),
        .rst               (rst),
        .cpu_xram_addr     (cpu_xram_addr),
        .cpu_xram_data_out (cpu_xram_data_out),
        .cpu_xram_stb      (cpu_xram_stb),
        .cpu_xram_wr       (cpu_xram_wr),
        .cpu_xram_data_in  (cpu_xram_data_in),
        .cpu_xram_ack      (cpu_xram_ack),
        .acc_xram_addr     (acc_xram_addr),
        .acc_xram_data_out (acc_xram_data_out),
        .acc_xram_stb      (acc_xram_stb),
        .acc_xram_wr       (acc_xram_wr),
        .acc_xram_data_in  (acc_xram_data_in),
        .acc_xram_ack      (acc_xram_ack),
        .xram_addr         (xram_addr),
        .xram_data_out     (xram_data_out),
        .xram_stb          (xram_stb),
        .xram_wr           (xram_wr),
        .xram_data_in      (xram_data_in),
        .xram_ack          (xram_ack),
        .arb_state         (arb_state),
        .arb_timeout       (arb_timeout)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, then let combinational paths settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        cpu_xram_addr = '0; cpu_xram_data_out = '0; cpu_xram_stb = 1'b0; cpu_xram_wr = 1'b0;
        acc_xram_addr = '0; acc_xram_data_out = '0; acc_xram_stb = 1'b0; acc_xram_wr = 1'b0;
        xram_data_in = '0; xram_ack = 1'b0;
        tick();
        tick();
        check("rst_state", arb_state, 2'b00);
        check("rst_timeout", arb_timeout, 1'b0);
        check("rst_xram_stb", xram_stb, 1'b0);
        check("rst_cpu_ack", cpu_xram_ack, 1'b0);

        // Tie after reset: CPU first, then ACC after one IDLE turnaround.
        rst = 1'b0;
        cpu_xram_stb = 1'b1; cpu_xram_addr = 16'h1234;
        acc_xram_stb = 1'b1; acc_xram_addr = 16'h0100;
        settle();
        check("c1_state", arb_state, 2'b00);
        check("c1_no_fwd_stb", xram_stb, 1'b0);
        check("c1_no_fwd_addr", xram_addr, 16'h0000);
        tick();
        check("c2_state", arb_state, 2'b01);
        check("c2_addr", xram_addr, 16'h1234);
        check("c2_stb", xram_stb, 1'b1);
        tick();
        check("c3_state", arb_state, 2'b01);
        tick();
        xram_ack = 1'b1; xram_data_in = 8'h77;
        settle();
        check("c4_cpu_ack", cpu_xram_ack, 1'b1);
        check("c4_cpu_data", cpu_xram_data_in, 8'h77);
        check("c4_acc_ack", acc_xram_ack, 1'b0);
        check("c4_acc_data", acc_xram_data_in, 8'h00);
        tick();
        xram_ack = 1'b0;
        settle();
        check("c5_state", arb_state, 2'b00);
        check("c5_cpu_ack", cpu_xram_ack, 1'b0);
        check("c5_xram_stb", xram_stb, 1'b0);
        tick();
        check("c6_state", arb_state, 2'b10);
        check("c6_addr", xram_addr, 16'h0100);

        // Read routing to the accelerator.
        xram_ack = 1'b1; xram_data_in = 8'hA5;
        settle();
        check("rd_acc_data", acc_xram_data_in, 8'hA5);
        check("rd_cpu_data", cpu_xram_data_in, 8'h00);
        check("rd_acc_ack", acc_xram_ack, 1'b1);
        check("rd_cpu_ack", cpu_xram_ack, 1'b0);
        tick();
        xram_ack = 1'b0; xram_data_in = 8'h00;
        cpu_xram_stb = 1'b0; acc_xram_stb = 1'b0;
        settle();
        check("rd_idle", arb_state, 2'b00);
        tick();
        check("rd_idle2", arb_state, 2'b00);

        // CPU write forwarded unchanged for the whole grant.
        cpu_xram_stb = 1'b1; cpu_xram_wr = 1'b1;
        cpu_xram_addr = 16'hF000; cpu_xram_data_out = 8'h3C;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("wr_state", arb_state, 2'b01);
            check("wr_wr", xram_wr, 1'b1);
            check("wr_data", xram_data_out, 8'h3C);
            check("wr_addr", xram_addr, 16'hF000);
            if (i < 2) tick();
        end
        xram_ack = 1'b1;
        settle();
        check("wr_cpu_ack", cpu_xram_ack, 1'b1);
        check("wr_wr_at_ack", xram_wr, 1'b1);
        tick();
        xram_ack = 1'b0; cpu_xram_stb = 1'b0; cpu_xram_wr = 1'b0;
        settle();
        check("wr_idle", arb_state, 2'b00);

        // Timeout: grant at E, wait_cnt reaches 4 at E+4, pulse at E+5.
        cpu_xram_stb = 1'b1; cpu_xram_addr = 16'h2000;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("to_wait_state", arb_state, 2'b01);
            check("to_wait_pulse", arb_timeout, 1'b0);
            check("to_wait_ack", cpu_xram_ack, 1'b0);
            tick();
        end
        cpu_xram_stb = 1'b0;
        settle();
        check("to_pulse", arb_timeout, 1'b1);
        check("to_state", arb_state, 2'b00);
        check("to_cpu_ack", cpu_xram_ack, 1'b0);
        tick();
        check("to_pulse_end", arb_timeout, 1'b0);

        // Reset during GNT_ACC with a coincident ack.
        acc_xram_stb = 1'b1; acc_xram_addr = 16'h0200;
        tick();
        check("rm_state", arb_state, 2'b10);
        rst = 1'b1; xram_ack = 1'b1;
        settle();
        check("rm_acc_ack_in_rst", acc_xram_ack, 1'b0);
        tick();
        check("rm_state_rst", arb_state, 2'b00);
        check("rm_acc_ack_after", acc_xram_ack, 1'b0);
        rst = 1'b0; acc_xram_stb = 1'b0;
        settle();
        check("rm_idle_ack_cpu", cpu_xram_ack, 1'b0);
        check("rm_idle_ack_acc", acc_xram_ack, 1'b0);
        tick();
        xram_ack = 1'b0;
        check("rm_still_idle", arb_state, 2'b00);

        // Alternation under continuous demand; CPU first proves last_gnt reset to 1.
        cpu_xram_stb = 1'b1; acc_xram_stb = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick();
            check("alt_grant", arb_state, (t % 2 == 0) ? 16'd1 : 16'd2);
            xram_ack = 1'b1;
            settle();
            check("alt_ack", (t % 2 == 0) ? cpu_xram_ack : acc_xram_ack, 1'b1);
            tick();
            xram_ack = 1'b0;
            settle();
            check("alt_idle", arb_state, 2'b00);
        end

        // Accelerator drops stb mid-grant: abort without ack.
        cpu_xram_stb = 1'b0;
        tick();
        check("ab_state", arb_state, 2'b10);
        acc_xram_stb = 1'b0;
        settle();
        check("ab_acc_ack", acc_xram_ack, 1'b0);
        check("ab_xram_stb", xram_stb, 1'b0);
        tick();
        check("ab_idle", arb_state, 2'b00);
        check("ab_acc_ack_after", acc_xram_ack, 1'b0);
        check("ab_no_timeout", arb_timeout, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
